// File: rtl/av2_pkg.sv
// rtl/av2_pkg.sv - shared OBU codes, error causes and FSM states for the AV2 decode controller
package av2_pkg;

    localparam logic [3:0]  OBU_SEQ_HDR   = 4'd1;
    localparam logic [3:0]  OBU_FRAME_HDR = 4'd3;
    localparam logic [3:0]  OBU_FRAME     = 4'd6;
    localparam logic [15:0] RESET_DIM     = 16'd64;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NO_SEQ  = 2'd1,
        ERR_BAD_DIM = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_HDR = 3'd1,
        ST_RECON    = 3'd2,
        ST_FILTER   = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    function automatic logic is_frame_obu(input logic [3:0] obu_type);
        return (obu_type == OBU_FRAME_HDR) || (obu_type == OBU_FRAME);
    endfunction

endpackage

// File: rtl/av2_stage_watchdog.sv
// rtl/av2_stage_watchdog.sv - per-stage cycle watchdog, restarted on every stage change
module av2_stage_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_eff;

    // clear is seen in the first cycle of a new stage, so that cycle already reads as count 0
    assign cnt_eff = clear ? '0 : cnt;
    assign expired = run && (cnt_eff == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_eff + W'(1);
        end
    end

endmodule

// File: rtl/av2_decode_ctrl.sv
// rtl/av2_decode_ctrl.sv - AV2 frame decode sequencer: OBU gating, header latch, recon/filter stages
module av2_decode_ctrl
    import av2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             obu_valid,
    input  logic [3:0]       obu_type,
    output logic             obu_ready,
    input  logic             header_valid,
    input  logic [1:0]       frame_type,
    input  logic [15:0]      frame_width,
    input  logic [15:0]      frame_height,
    output logic             header_ready,
    output logic             recon_start,
    input  logic             recon_done,
    output logic             filter_start,
    input  logic             filter_done,
    input  logic             cfg_lf_en,
    input  logic             err_clear,
    output logic [1:0]       cur_frame_type,
    output logic [15:0]      cur_width,
    output logic [15:0]      cur_height,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code
);

    state_t    state;
    state_t    state_prev;
    err_code_t err_code_q;
    logic      seq_seen;
    logic      seq_err_pending;
    logic      obu_fire;
    logic      dim_bad;
    logic      wd_run;
    logic      wd_clear;
    logic      wd_expired;

    assign obu_ready    = (state == ST_IDLE) && !seq_err_pending;
    assign obu_fire     = obu_valid && obu_ready;
    assign header_ready = (state == ST_WAIT_HDR) && header_valid;
    assign dim_bad      = (frame_width == 16'd0) || (frame_height == 16'd0);

    // Outputs are pure decodes of the state register, so reset drops them asynchronously
    assign recon_start  = (state == ST_RECON);
    assign filter_start = (state == ST_FILTER);
    assign frame_done   = (state == ST_DONE);
    assign busy         = (state != ST_IDLE);
    assign err          = (state == ST_ERR);
    assign err_code     = err_code_q;

    assign wd_run   = (state == ST_WAIT_HDR) || (state == ST_RECON) || (state == ST_FILTER);
    assign wd_clear = (state != state_prev);

    av2_stage_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .run    (wd_run),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            state_prev      <= ST_IDLE;
            err_code_q      <= ERR_NONE;
            seq_seen        <= 1'b0;
            seq_err_pending <= 1'b0;
            frame_count     <= '0;
            cur_frame_type  <= 2'd0;
            cur_width       <= RESET_DIM;
            cur_height      <= RESET_DIM;
        end else begin
            state_prev <= state;
            unique case (state)
                ST_IDLE: begin
                    if (obu_fire) begin
                        if (obu_type == OBU_SEQ_HDR) begin
                            seq_seen <= 1'b1;
                        end else if (is_frame_obu(obu_type)) begin
                            if (seq_seen) begin
                                state <= ST_WAIT_HDR;
                            end else begin
                                state           <= ST_ERR;
                                err_code_q      <= ERR_NO_SEQ;
                                seq_err_pending <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT_HDR: begin
                    if (header_valid) begin
                        cur_frame_type <= frame_type;
                        cur_width      <= frame_width;
                        cur_height     <= frame_height;
                        if (dim_bad) begin
                            state      <= ST_ERR;
                            err_code_q <= ERR_BAD_DIM;
                        end else begin
                            state <= ST_RECON;
                        end
                    end else if (wd_expired) begin
                        state      <= ST_ERR;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                ST_RECON: begin
                    // A done on the expiry cycle wins over the watchdog
                    if (recon_done) begin
                        state <= cfg_lf_en ? ST_FILTER : ST_DONE;
                    end else if (wd_expired) begin
                        state      <= ST_ERR;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                ST_FILTER: begin
                    if (filter_done) begin
                        state <= ST_DONE;
                    end else if (wd_expired) begin
                        state      <= ST_ERR;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    frame_count <= frame_count + CNT_W'(1);
                    state       <= ST_IDLE;
                end
                ST_ERR: begin
                    if (err_clear) begin
                        state           <= ST_IDLE;
                        err_code_q      <= ERR_NONE;
                        seq_seen        <= 1'b0;
                        seq_err_pending <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_av2_decode_ctrl.sv
// tb/tb_av2_decode_ctrl.sv - randomized scoreboard bench for av2_decode_ctrl
module tb_av2_decode_ctrl;
    import av2_pkg::*;

    localparam int T  = 16;
    localparam int CW = 4;
    localparam int W_RECON  = 0;
    localparam int W_FILTER = 1;
    localparam int W_EMPTY  = 2;
    localparam int W_IDLE   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          obu_valid = 1'b0;
    logic [3:0]    obu_type = 4'd0;
    logic          obu_ready;
    logic          header_valid = 1'b0;
    logic [1:0]    frame_type = 2'd0;
    logic [15:0]   frame_width = 16'd0;
    logic [15:0]   frame_height = 16'd0;
    logic          header_ready;
    logic          recon_start;
    logic          recon_done = 1'b0;
    logic          filter_start;
    logic          filter_done = 1'b0;
    logic          cfg_lf_en = 1'b0;
    logic          err_clear = 1'b0;
    logic [1:0]    cur_frame_type;
    logic [15:0]   cur_width;
    logic [15:0]   cur_height;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;

    av2_decode_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .obu_valid(obu_valid), .obu_type(obu_type), .obu_ready(obu_ready),
        .header_valid(header_valid), .frame_type(frame_type),
        .frame_width(frame_width), .frame_height(frame_height), .header_ready(header_ready),
        .recon_start(recon_start), .recon_done(recon_done),
        .filter_start(filter_start), .filter_done(filter_done),
        .cfg_lf_en(cfg_lf_en), .err_clear(err_clear),
        .cur_frame_type(cur_frame_type), .cur_width(cur_width), .cur_height(cur_height),
        .frame_done(frame_done), .frame_count(frame_count),
        .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // kind 0 = completed frame, kind 1 = error entry
    typedef struct {
        int kind;
        int code;
        int ftype;
        int w;
        int h;
        int count;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   model_count = 0;
    bit   model_seq = 1'b0;
    logic err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input int ftype, input int w, input int h);
        exp_t e;
        e = '{0, 0, ftype, w, h, model_count};
        sb.push_back(e);
        model_count = (model_count + 1) % (1 << CW);
    endtask

    task automatic push_err(input int code);
        exp_t e;
        e = '{1, code, 0, 0, 0, 0};
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                err_prev = 1'b0;
                continue;
            end
            if (frame_done) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame_done: frame_done with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_frame", 0, e.kind);
                    chk("cur_frame_type", cur_frame_type, e.ftype);
                    chk("cur_width", cur_width, e.w);
                    chk("cur_height", cur_height, e.h);
                    chk("frame_count_at_done", frame_count, e.count);
                end
            end
            if (err && !err_prev) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: err code %0d with empty scoreboard", err_code);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_err", 1, e.kind);
                    chk("err_code", err_code, e.code);
                end
            end
            err_prev = err;
        end
    end

    function automatic logic probe(input int which);
        case (which)
            W_RECON:  return recon_start;
            W_FILTER: return filter_start;
            W_EMPTY:  return sb.size() == 0;
            default:  return !busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int cyc;
        cyc = 0;
        while (!probe(which) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!probe(which)) begin
            checks++; errors++;
            $display("FAIL wait_%s: event absent after %0d cycles, required within 100", name, cyc);
        end
    endtask

    task automatic send_obu(input logic [3:0] t);
        wait_for(W_IDLE, "idle_before_obu");
        obu_valid = 1'b1;
        obu_type  = t;
        chk("obu_ready_idle", obu_ready, 1);
        @(negedge clk);
        obu_valid = 1'b0;
    endtask

    task automatic clear_err();
        wait_for(W_EMPTY, "err_event");
        chk("err_sticky", err, 1);
        chk("obu_ready_in_err", obu_ready, 0);
        chk("recon_start_in_err", recon_start, 0);
        chk("filter_start_in_err", filter_start, 0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("err_after_clear", err, 0);
        chk("err_code_after_clear", err_code, 0);
        chk("busy_after_clear", busy, 0);
        model_seq = 1'b0;
    endtask

    // Drives one frame attempt and queues the outcome the rules predict for it
    task automatic run_frame(input bit send_seq, input logic [3:0] typ, input int ftype,
                             input int w, input int h, input int hdr_d,
                             input int rec_d, input int fil_d, input bit lf);
        int cyc;
        if (send_seq) begin
            send_obu(OBU_SEQ_HDR);
            model_seq = 1'b1;
        end
        if (!model_seq) begin
            push_err(1);
            send_obu(typ);
            clear_err();
            return;
        end
        send_obu(typ);
        repeat (hdr_d) @(negedge clk);
        if (w == 0 || h == 0) push_err(2);
        header_valid = 1'b1;
        frame_type   = 2'(ftype);
        frame_width  = 16'(w);
        frame_height = 16'(h);
        #1 chk("header_ready_pulse", header_ready, 1);
        @(negedge clk);
        chk("header_ready_one_cycle", header_ready, 0);
        header_valid = 1'b0;
        if (w == 0 || h == 0) begin
            clear_err();
            return;
        end
        wait_for(W_RECON, "recon_start");
        cfg_lf_en = !lf;
        if (rec_d >= T) begin
            push_err(3);
            cyc = 0;
            while (!err && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            chk("recon_timeout_cycles", cyc, T);
            clear_err();
            return;
        end
        if (rec_d > 0) begin
            filter_done = 1'b1;
            @(negedge clk);
            filter_done = 1'b0;
            repeat (rec_d - 1) @(negedge clk);
        end
        cfg_lf_en  = lf;
        recon_done = 1'b1;
        if (!lf) push_frame(ftype, w, h);
        @(negedge clk);
        recon_done = 1'b0;
        cfg_lf_en  = !lf;
        if (!lf) begin
            chk("lf_off_done_next_cycle", frame_done, 1);
            chk("lf_off_no_filter", filter_start, 0);
        end else begin
            wait_for(W_FILTER, "filter_start");
            if (fil_d >= T) begin
                push_err(3);
                clear_err();
                return;
            end
            if (fil_d > 0) begin
                recon_done = 1'b1;
                @(negedge clk);
                recon_done = 1'b0;
                repeat (fil_d - 1) @(negedge clk);
            end
            filter_done = 1'b1;
            push_frame(ftype, w, h);
            @(negedge clk);
            filter_done = 1'b0;
        end
        wait_for(W_EMPTY, "frame_done");
        wait_for(W_IDLE, "idle_after_frame");
        chk("frame_count", frame_count, model_count);
    endtask

    initial begin : global_limit
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stimulus
        bit ok;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_cur_frame_type", cur_frame_type, 0);
        chk("rst_cur_width", cur_width, 64);
        chk("rst_cur_height", cur_height, 64);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_recon_start", recon_start, 0);
        chk("rst_filter_start", filter_start, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("obu_ready_after_rst", obu_ready, 1);

        // Frame OBU without sequence header, then the reference frame
        run_frame(0, OBU_FRAME, 0, 64, 48, 0, 5, 7, 1);
        run_frame(1, OBU_FRAME_HDR, 1, 64, 48, 0, 5, 7, 1);
        chk("first_frame_count", frame_count, 1);
        chk("first_cur_width", cur_width, 64);
        chk("first_cur_height", cur_height, 48);

        run_frame(0, OBU_FRAME, 2, 320, 240, 1, 3, 0, 0);
        run_frame(0, OBU_FRAME_HDR, 0, 100, 50, 0, T, 0, 1);
        run_frame(1, OBU_FRAME_HDR, 3, 16, 16, 2, T - 1, 0, 0);
        run_frame(0, OBU_FRAME, 1, 32, 32, 0, 2, T - 1, 1);
        run_frame(0, OBU_FRAME, 1, 32, 32, 0, 2, T, 1);
        run_frame(1, OBU_FRAME, 0, 0, 32, 0, 0, 0, 0);
        run_frame(1, OBU_FRAME, 0, 32, 0, 0, 0, 0, 0);

        send_obu(4'd2);
        chk("junk_obu_stays_idle", busy, 0);
        send_obu(4'd15);
        chk("junk_obu_ready", obu_ready, 1);

        for (int i = 0; i < 40; i++) begin
            run_frame($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 1) != 0) ? OBU_FRAME : OBU_FRAME_HDR,
                      int'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 65535)),
                      ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 65535)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)),
                      int'($urandom_range(0, T + 1)), $urandom_range(0, 1) != 0);
        end

        // Run complete frames until the counter wraps back to zero
        ok = 1'b0;
        for (int i = 0; i < 17 && !ok; i++) begin
            run_frame(i == 0, OBU_FRAME, i % 4, 8 + i, 8, 0, 1, 1, i % 2);
            ok = (model_count == 0);
        end
        chk("wrap_to_zero", frame_count, 0);
        run_frame(0, OBU_FRAME, 2, 40, 30, 0, 1, 1, 1);
        chk("count_after_wrap", frame_count, 1);

        // Reset in the middle of the loop-filter stage
        send_obu(OBU_FRAME);
        header_valid = 1'b1; frame_type = 2'd1; frame_width = 16'd80; frame_height = 16'd60;
        @(negedge clk);
        header_valid = 1'b0;
        wait_for(W_RECON, "recon_before_rst");
        cfg_lf_en = 1'b1; recon_done = 1'b1;
        @(negedge clk);
        recon_done = 1'b0;
        wait_for(W_FILTER, "filter_before_rst");
        chk("filter_active_before_rst", filter_start, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_filter_start_async", filter_start, 0);
        chk("rst_recon_start_async", recon_start, 0);
        chk("rst_busy_async", busy, 0);
        chk("rst_frame_count_async", frame_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_count = 0;
        model_seq = 1'b0;
        repeat (4) @(negedge clk);
        chk("aborted_frame_not_counted", frame_count, 0);
        chk("aborted_no_frame_done", frame_done, 0);
        run_frame(1, OBU_FRAME_HDR, 3, 64, 64, 0, 2, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/av2_decode_ctrl.md
AV2_DECODE_CTRL -- requirements
Module: av2_decode_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the per-stage watchdog limit in clk cycles.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the frame counter width.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  (clock); rst_n  in  1  (async reset, active low).
REQ-004 obu_valid  in  1  parsed OBU available; obu_type  in  4  OBU type; obu_ready  out  1  OBU accepted.
REQ-005 header_valid  in  1  frame header parsed; frame_type  in  2  frame type; frame_width / frame_height  in  16 each  frame dimensions; header_ready  out  1  header consumed.
REQ-006 recon_start  out  1  reconstruction run (level); recon_done  in  1  reconstruction finished.
REQ-007 filter_start  out  1  loop-filter run (level); filter_done  in  1  loop filter finished.
REQ-008 cfg_lf_en  in  1  loop filter enable; err_clear  in  1  clear the error state.
REQ-009 cur_frame_type  out  2, cur_width  out  16, cur_height  out  16  latched header fields.
REQ-010 frame_done  out  1  one-cycle completion pulse; frame_count  out  CNT_W  frames completed; busy  out  1  state not IDLE; err  out  1  sticky error; err_code  out  2  error cause.

Function
REQ-011 SHALL implement states IDLE, WAIT_HDR, RECON, FILTER, DONE, ERR.
REQ-012 obu_ready SHALL equal (state==IDLE && !seq_err_pending), combinationally; an OBU transfers on obu_valid && obu_ready.
REQ-013 In IDLE, a transferred OBU with type 1 (SEQ_HDR) SHALL set the internal flag seq_seen and remain in IDLE.
REQ-014 In IDLE, a transferred OBU with type 3 (FRAME_HDR) or type 6 (FRAME) and seq_seen=1 SHALL go to WAIT_HDR on the next cycle.
REQ-015 In IDLE, a transferred OBU with type 3 or 6 and seq_seen=0 SHALL go to ERR with err_code=2'd1.
REQ-016 In IDLE, transferred OBUs of any other type SHALL be consumed and dropped, with no state change.
REQ-017 In WAIT_HDR, header_valid SHALL assert header_ready for exactly one cycle, latch frame_type, width and height into the cur_* outputs, and go to RECON.
REQ-018 In WAIT_HDR, frame_width==0 or frame_height==0 SHALL go to ERR with err_code=2'd2, still pulsing header_ready.
REQ-019 recon_start SHALL be 1 exactly while state==RECON.
REQ-020 In RECON, recon_done SHALL go to FILTER if cfg_lf_en=1, else to DONE; cfg_lf_en is sampled on that cycle.
REQ-021 filter_start SHALL be 1 exactly while state==FILTER; in FILTER, filter_done SHALL go to DONE.
REQ-022 DONE SHALL last one cycle, assert frame_done, increment frame_count with wrap from 2^CNT_W-1 to 0, and return to IDLE.
REQ-023 The watchdog SHALL clear on every state change and count while in WAIT_HDR, RECON or FILTER; reaching TIMEOUT_CYCLES-1 SHALL go to ERR with err_code=2'd3.
REQ-024 A done input arriving on the same cycle as timeout expiry SHALL take priority: the done input is honoured and no error is raised.
REQ-025 In ERR, err SHALL be 1, obu_ready, recon_start and filter_start SHALL be 0, and err_clear SHALL return to IDLE with err=0, err_code=0 and seq_seen=0.
REQ-026 recon_done or filter_done outside its own state SHALL be ignored.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 While rst_n=0 SHALL set: state=IDLE; seq_seen=0; watchdog=0; frame_count=0; cur_frame_type=0; cur_width=64; cur_height=64; all strobes and start outputs=0; err=0; err_code=0.
REQ-029 Reset asserted mid-frame SHALL abort immediately: recon_start and filter_start drop asynchronously and frame_count is not incremented.

Structure
REQ-030 OBU type codes, err_code values and state encodings SHALL live in shared package av2_pkg.
REQ-031 The watchdog SHALL be sub-module av2_stage_watchdog with inputs clear and run, and output expired.

Verification
REQ-032 SEQ_HDR OBU, then FRAME_HDR OBU, header 64x48, recon_done after 5 cycles, filter_done after 7 cycles, cfg_lf_en=1 -> one frame_done pulse, frame_count=1, cur_width=64, cur_height=48.
REQ-033 FRAME OBU without a prior SEQ_HDR -> ERR, err_code=1, obu_ready=0; err_clear -> IDLE.
REQ-034 cfg_lf_en=0 -> filter_start never asserts; frame_done occurs the cycle after leaving RECON.
REQ-035 TIMEOUT_CYCLES=16 with recon_done withheld -> err_code=3 after 16 cycles in RECON; a second run with recon_done on the expiry cycle -> no error.
REQ-036 CNT_W=4, 16 consecutive frames -> frame_count wraps to 0; rst_n pulsed during FILTER -> filter_start=0 immediately, frame_count unchanged.
